// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and types for the MUL dispatch block
package mul_pkg;

    // Opcodes of the four multiply forms; bit 0 selects the register form
    localparam logic [6:0] OP_MULI  = 7'b0111100;
    localparam logic [6:0] OP_MULR  = 7'b0111101;
    localparam logic [6:0] OP_MULSI = 7'b0111110;
    localparam logic [6:0] OP_MULSR = 7'b0111111;

    localparam logic [31:0] NOP_INSTR = {5'b11001, 27'b0};

    // Field bit positions within the instruction word
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 25;
    localparam int RD_MSB  = 24;
    localparam int RD_LSB  = 21;
    localparam int RS_MSB  = 20;
    localparam int RS_LSB  = 17;
    localparam int RS2_MSB = 16;
    localparam int RS2_LSB = 13;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        MT_MULI  = 2'd0,
        MT_MULR  = 2'd1,
        MT_MULSI = 2'd2,
        MT_MULSR = 2'd3
    } mul_type_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_DRAIN   = 3'd3,
        S_RELEASE = 3'd4
    } state_e;

endpackage

// File: rtl/mul_field_decode.sv
// rtl/mul_field_decode.sv - combinational MUL opcode and operand field decoder
module mul_field_decode
    import mul_pkg::*;
#(
    parameter bit ENABLE_MULSR = 1'b0
) (
    input  logic [31:0] i_instr,
    output logic        o_is_mul,
    output logic [1:0]  o_mul_type,
    output logic [3:0]  o_rd,
    output logic [3:0]  o_rs,
    output logic [3:0]  o_rs2,
    output logic [15:0] o_imm,
    output logic        o_illegal
);

    logic [6:0] w_opc;

    assign w_opc = i_instr[OPC_MSB:OPC_LSB];
    assign o_rd  = i_instr[RD_MSB:RD_LSB];
    assign o_rs  = i_instr[RS_MSB:RS_LSB];
    assign o_rs2 = i_instr[RS2_MSB:RS2_LSB];
    assign o_imm = i_instr[IMM_MSB:IMM_LSB];

    // Classify the opcode; MULSR is flagged illegal when the sequencer lacks support
    always_comb begin
        o_is_mul   = 1'b1;
        o_mul_type = MT_MULI;
        o_illegal  = 1'b0;
        case (w_opc)
            OP_MULI:  o_mul_type = MT_MULI;
            OP_MULR:  o_mul_type = MT_MULR;
            OP_MULSI: o_mul_type = MT_MULSI;
            OP_MULSR: begin
                o_mul_type = MT_MULSR;
                o_illegal  = !ENABLE_MULSR;
            end
            default:  o_is_mul = 1'b0;
        endcase
    end

endmodule

// File: rtl/mul_dispatch.sv
// rtl/mul_dispatch.sv - MUL microcode launch handshake between IF and the injection mux
module mul_dispatch
    import mul_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 4,
    parameter bit ENABLE_MULSR = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr,
    input  logic        if_valid,
    input  logic        ucode_busy,
    output logic [31:0] id_instr,
    output logic        pc_stall,
    output logic        start_mul,
    output logic [3:0]  dest_reg,
    output logic [3:0]  source_reg,
    output logic [3:0]  rs2_addr,
    output logic [15:0] immediate,
    output logic [1:0]  mul_type,
    output logic        mul_error,
    output logic [15:0] mul_retired_cnt
);

    localparam logic [7:0] TIMER_LAST = 8'(BUSY_TIMEOUT - 1);

    state_e      r_state;
    state_e      w_next;
    logic [7:0]  r_timer;
    logic [3:0]  r_rd;
    logic [3:0]  r_rs;
    logic [3:0]  r_rs2;
    logic [15:0] r_imm;
    logic [1:0]  r_type;
    logic        r_from_drain;
    logic [15:0] r_cnt;

    logic        w_is_mul;
    logic [1:0]  w_type;
    logic [3:0]  w_rd;
    logic [3:0]  w_rs;
    logic [3:0]  w_rs2;
    logic [15:0] w_imm;
    logic        w_illegal;
    logic        w_latch;
    logic        w_stall;
    logic        w_start;
    logic        w_err;
    logic [31:0] w_id;

    mul_field_decode #(
        .ENABLE_MULSR(ENABLE_MULSR)
    ) u_decode (
        .i_instr   (if_instr),
        .o_is_mul  (w_is_mul),
        .o_mul_type(w_type),
        .o_rd      (w_rd),
        .o_rs      (w_rs),
        .o_rs2     (w_rs2),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake outputs; a MUL seen while busy is still high waits in IDLE
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_start = 1'b0;
        w_err   = 1'b0;
        w_latch = 1'b0;
        w_id    = NOP_INSTR;
        case (r_state)
            S_IDLE: begin
                if (if_valid && w_is_mul) begin
                    w_stall = 1'b1;
                    if (ucode_busy) begin
                        w_next = S_IDLE;
                    end else if (w_illegal) begin
                        w_err  = 1'b1;
                        w_next = S_RELEASE;
                    end else begin
                        w_latch = 1'b1;
                        w_next  = S_LAUNCH;
                    end
                end else begin
                    w_id = if_instr;
                end
            end
            S_LAUNCH: begin
                w_stall = 1'b1;
                w_start = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (ucode_busy) begin
                    w_next = S_DRAIN;
                end else if (r_timer == TIMER_LAST) begin
                    w_err  = 1'b1;
                    w_next = S_RELEASE;
                end
            end
            S_DRAIN: begin
                w_stall = 1'b1;
                if (!ucode_busy) w_next = S_RELEASE;
            end
            S_RELEASE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latches; register forms force immediate=1 to avoid the sequencer clear path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd   <= 4'd0;
            r_rs   <= 4'd0;
            r_rs2  <= 4'd0;
            r_imm  <= 16'd0;
            r_type <= 2'd0;
        end else if (w_latch) begin
            r_rd   <= w_rd;
            r_rs   <= w_rs;
            r_rs2  <= w_rs2;
            r_imm  <= w_type[0] ? 16'd1 : w_imm;
            r_type <= w_type;
        end
    end

    // Busy-rise timeout timer, cleared on launch and advanced while waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_timer <= 8'd0;
        else if (r_state == S_LAUNCH) r_timer <= 8'd0;
        else if (r_state == S_WAIT)   r_timer <= r_timer + 8'd1;
    end

    // Retire counter: only releases that followed a busy fall count as completed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_from_drain <= 1'b0;
            r_cnt        <= 16'd0;
        end else begin
            r_from_drain <= (r_state == S_DRAIN);
            if (r_state == S_RELEASE && r_from_drain) r_cnt <= r_cnt + 16'd1;
        end
    end

    // Outputs are forced to their idle values while reset is asserted
    assign pc_stall        = w_stall & ~rst;
    assign start_mul       = w_start & ~rst;
    assign mul_error       = w_err & ~rst;
    assign id_instr        = rst ? NOP_INSTR : w_id;
    assign rs2_addr        = (r_state == S_LAUNCH) ? r_rs2 : if_instr[RS2_MSB:RS2_LSB];
    assign dest_reg        = r_rd;
    assign source_reg      = r_rs;
    assign immediate       = r_imm;
    assign mul_type        = r_type;
    assign mul_retired_cnt = r_cnt;

endmodule
